i2s_rx_deser: RTL and testbench

//  I2S (Philips) slave receiver for the user-logic audio pads. Samples external SCK/WS/SD (pad O side) in the

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_rx_fifo.sv | 64 ++++++
 rtl/i2s_rx_deser.sv | 175 +++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive path: FSM state encoding, default word width, L/R pair layout.
package i2s_pkg;

    localparam int I2S_DATA_W_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } i2s_rx_state_e;

    // Default-width pair; modules with a different DATA_W declare the same layout locally.
    typedef struct packed {
        logic [I2S_DATA_W_DFLT-1:0] left;
        logic [I2S_DATA_W_DFLT-1:0] right;
    } i2s_pair_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through sync FIFO holding L/R pairs; a push into a full FIFO is accepted only with a same-cycle pop.
// Optional occupancy output when I2S_RX_LEVEL_EN is defined.
module i2s_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
`ifdef I2S_RX_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

`ifdef I2S_RX_LEVEL_EN
    assign level = count;
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S (Philips) slave receiver: pad synchronisers, SCK edge detect, L/R deserialiser FSM, pair FIFO, sticky overrun.
// Defining I2S_RX_LEVEL_EN adds the fifo_level_o occupancy port.
//
//  state | meaning
//  IDLE  | receiver disabled, FIFO flushed
//  SYNC  | enabled, waiting for first WS 1->0 change edge
//  LEFT  | shifting left-channel word
//  RIGHT | shifting right-channel word; 1->0 change edge pushes the pair
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W_DFLT,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              i2s_sck_i,
    input  logic              i2s_ws_i,
    input  logic              i2s_sd_i,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic [DATA_W-1:0] sample_left_o,
    output logic [DATA_W-1:0] sample_right_o,
    output logic              overrun_o,
    input  logic              clr_overrun_i
`ifdef I2S_RX_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_s, ws_s, sd_s;
    logic                   sck_prev, ws_prev;
    logic                   sck_rise, change;

    i2s_rx_state_e     state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] word, word_nxt, left_word;
    logic              push_q;
    pair_t             push_pair, head;
    logic              fifo_full, fifo_empty, fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sd_i};
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_prev;
    assign change   = sck_rise && (ws_s != ws_prev);

    // Bits beyond DATA_W are dropped; unused LSBs of short slots stay 0.
    always_comb begin
        word_nxt = word;
        if (bit_cnt < CNT_W'(DATA_W)) begin
            word_nxt = word | (DATA_W'(sd_s) << (CNT_W'(DATA_W - 1) - bit_cnt));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sck_prev  <= 1'b0;
            ws_prev   <= 1'b0;
            bit_cnt   <= '0;
            word      <= '0;
            left_word <= '0;
            push_q    <= 1'b0;
            push_pair <= '0;
        end else begin
            sck_prev <= sck_s;
            push_q   <= 1'b0;
            if (sck_rise) begin
                ws_prev <= ws_s;
            end
            if (!en_i) begin
                state   <= IDLE;
                bit_cnt <= '0;
                word    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= SYNC;
                        bit_cnt <= '0;
                        word    <= '0;
                    end
                    SYNC: begin
                        if (change && !ws_s) begin
                            state   <= LEFT;
                            bit_cnt <= '0;
                            word    <= '0;
                        end
                    end
                    LEFT, RIGHT: begin
                        if (change) begin
                            // Change edge carries the LSB of the word that is ending.
                            if (state == LEFT) begin
                                left_word <= word_nxt;
                                state     <= RIGHT;
                            end else begin
                                push_q    <= 1'b1;
                                push_pair <= '{left: left_word, right: word_nxt};
                                state     <= LEFT;
                            end
                            bit_cnt <= '0;
                            word    <= '0;
                        end else if (sck_rise) begin
                            word <= word_nxt;
                            if (bit_cnt < CNT_W'(DATA_W)) begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign fifo_pop = sample_ready_i && !fifo_empty;

    i2s_rx_fifo #(
        .WIDTH(2 * DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(!en_i),
        .push (push_q),
        .pop  (fifo_pop),
        .wdata(push_pair),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
`ifdef I2S_RX_LEVEL_EN
        ,
        .level(fifo_level_o)
`endif
    );

    assign sample_valid_o = !fifo_empty;
    assign sample_left_o  = fifo_empty ? '0 : head.left;
    assign sample_right_o = fifo_empty ? '0 : head.right;

    // Setting wins over a same-cycle clear so a drop is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_o <= 1'b0;
        end else if (push_q && en_i && fifo_full && !fifo_pop) begin
            overrun_o <= 1'b1;
        end else if (clr_overrun_i) begin
            overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed self-checking bench for i2s_rx_deser; level checks are active when I2S_RX_LEVEL_EN is defined.
module tb_i2s_rx_deser;
    import i2s_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        i2s_sck_i = 1'b0;
    logic        i2s_ws_i = 1'b0;
    logic        i2s_sd_i = 1'b0;
    logic        sample_valid_o;
    logic        sample_ready_i = 1'b0;
    logic [15:0] sample_left_o;
    logic [15:0] sample_right_o;
    logic        overrun_o;
    logic        clr_overrun_i = 1'b0;
`ifdef I2S_RX_LEVEL_EN
    logic [2:0]  fifo_level_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2s_rx_deser dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .i2s_sck_i     (i2s_sck_i),
        .i2s_ws_i      (i2s_ws_i),
        .i2s_sd_i      (i2s_sd_i),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .sample_left_o (sample_left_o),
        .sample_right_o(sample_right_o),
        .overrun_o     (overrun_o),
        .clr_overrun_i (clr_overrun_i)
`ifdef I2S_RX_LEVEL_EN
        ,
        .fifo_level_o  (fifo_level_o)
`endif
    );

    // One SCK period: 2 clk low with WS/SD changing, 2 clk high. Entered and left at a clk negedge.
    task automatic send_edge(input logic ws, input logic sd);
        i2s_sck_i = 1'b0;
        i2s_ws_i  = ws;
        i2s_sd_i  = sd;
        repeat (2) @(negedge clk);
        i2s_sck_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_sync();
        repeat (3) send_edge(1'b1, 1'b0);
        send_edge(1'b0, 1'b0);
    endtask

    // Frame of n-bit slots starting just after a 1->0 change edge; last=1 sends the closing change edge.
    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit last);
        for (int j = n - 1; j >= 1; j--) send_edge(1'b0, l[j]);
        send_edge(1'b1, l[0]);
        for (int j = n - 1; j >= 1; j--) send_edge(1'b1, r[j]);
        if (last) begin
            send_edge(1'b0, r[0]);
            repeat (3) @(negedge clk);
        end
    endtask

    // Closing edge with a one-cycle clr/ready strobe aligned to the cycle the pair reaches the FIFO.
    task automatic timed_final(input logic sd, input bit do_clr, input bit do_pop);
        i2s_sck_i = 1'b0;
        i2s_ws_i  = 1'b0;
        i2s_sd_i  = sd;
        repeat (2) @(negedge clk);
        i2s_sck_i = 1'b1;
        repeat (3) @(negedge clk);
        clr_overrun_i  = do_clr;
        sample_ready_i = do_pop;
        @(negedge clk);
        clr_overrun_i  = 1'b0;
        sample_ready_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_head(output logic v, output logic [15:0] l, output logic [15:0] r);
        v = sample_valid_o;
        l = sample_left_o;
        r = sample_right_o;
        sample_ready_i = 1'b1;
        @(negedge clk);
        sample_ready_i = 1'b0;
    endtask

    task automatic restart();
        en_i = 1'b0;
        @(negedge clk);
        en_i = 1'b1;
        @(negedge clk);
        send_sync();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i2s_sck_i = ~i2s_sck_i;
            i2s_ws_i  = (i % 2) == 0;
            i2s_sd_i  = ~i2s_sd_i;
        end
        @(negedge clk);
        n_checks++;
        if ({sample_valid_o, sample_left_o, sample_right_o, overrun_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%h r=%h ovr=%b, want all 0",
                     sample_valid_o, sample_left_o, sample_right_o, overrun_o);
        end
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, want IDLE", dut.state);
        end
        rst = 1'b0;
        i2s_sck_i = 1'b0;
        i2s_ws_i  = 1'b0;
        i2s_sd_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic v;
        logic [15:0] l, r;
        restart();
        send_frame(32'hA5C3, 32'h1234, 16, 1'b0);
        i2s_sck_i = 1'b0;
        i2s_ws_i  = 1'b0;
        i2s_sd_i  = 1'b0;
        repeat (2) @(negedge clk);
        i2s_sck_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: valid=%b 3 clk after SCK rise, want 0", sample_valid_o);
        end
        @(negedge clk);
        n_checks++;
        if (sample_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: valid=%b 4 clk after SCK rise, want 1", sample_valid_o);
        end
        pop_head(v, l, r);
        n_checks++;
        if ({l, r} !== 32'hA5C3_1234) begin
            n_fail++;
            $display("FAIL basic_pair: got %h/%h, want a5c3/1234", l, r);
        end
        n_checks++;
        if (sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: valid=%b after pop, want 0", sample_valid_o);
        end
    endtask

    task automatic test_mid_right_enable();
        logic v;
        logic [15:0] l, r;
        en_i = 1'b0;
        @(negedge clk);
        repeat (5) send_edge(1'b0, 1'b1);
        repeat (3) send_edge(1'b1, 1'b1);
        en_i = 1'b1;
        repeat (2) @(negedge clk);
        repeat (5) send_edge(1'b1, 1'b1);
        send_edge(1'b0, 1'b1);
        send_frame(32'hBEEF, 32'h0F0F, 16, 1'b1);
        pop_head(v, l, r);
        n_checks++;
        if ({v, l, r} !== {1'b1, 32'hBEEF_0F0F}) begin
            n_fail++;
            $display("FAIL mid_enable_pair: got v=%b %h/%h, want 1 beef/0f0f", v, l, r);
        end
        n_checks++;
        if (sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_enable_extra: valid=%b after one pop, want 0", sample_valid_o);
        end
    endtask

    task automatic test_overrun();
        logic v;
        logic [15:0] l, r;
        restart();
        for (int i = 0; i < 5; i++) begin
            send_frame(32'h1100 + i, 32'h2200 + i, 16, 1'b1);
`ifdef I2S_RX_LEVEL_EN
            n_checks++;
            if (fifo_level_o !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
                n_fail++;
                $display("FAIL level_fill[%0d]: got %0d", i, fifo_level_o);
            end
`endif
        end
        n_checks++;
        if (overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b, want 1", overrun_o);
        end
        for (int i = 0; i < 4; i++) begin
            pop_head(v, l, r);
            n_checks++;
            if ({v, l, r} !== {1'b1, 16'h1100 + 16'(i), 16'h2200 + 16'(i)}) begin
                n_fail++;
                $display("FAIL order[%0d]: got v=%b %h/%h, want 1 %h/%h", i, v, l, r,
                         16'h1100 + 16'(i), 16'h2200 + 16'(i));
            end
`ifdef I2S_RX_LEVEL_EN
            n_checks++;
            if (fifo_level_o !== 3'(3 - i)) begin
                n_fail++;
                $display("FAIL level_drain[%0d]: got %0d, want %0d", i, fifo_level_o, 3 - i);
            end
`endif
        end
        n_checks++;
        if (sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drained: valid=%b, want 0", sample_valid_o);
        end
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        n_checks++;
        if (overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clr: got %b, want 0", overrun_o);
        end
        for (int i = 0; i < 4; i++) send_frame(32'h3300 + i, 32'h4400 + i, 16, 1'b1);
        send_frame(32'h3304, 32'h4404, 16, 1'b0);
        timed_final(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clr: got %b, want 1", overrun_o);
        end
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        send_frame(32'h5555, 32'h6666, 16, 1'b0);
        timed_final(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop_overrun: got %b, want 0", overrun_o);
        end
        for (int i = 1; i < 4; i++) begin
            pop_head(v, l, r);
            n_checks++;
            if ({v, l, r} !== {1'b1, 16'h3300 + 16'(i), 16'h4400 + 16'(i)}) begin
                n_fail++;
                $display("FAIL refill[%0d]: got v=%b %h/%h", i, v, l, r);
            end
        end
        pop_head(v, l, r);
        n_checks++;
        if ({v, l, r} !== {1'b1, 32'h5555_6666}) begin
            n_fail++;
            $display("FAIL push_on_pop: got v=%b %h/%h, want 1 5555/6666", v, l, r);
        end
    endtask

    task automatic test_slot_width();
        logic v;
        logic [15:0] l, r;
        restart();
        send_frame(32'hABCDEF, 32'h123456, 24, 1'b1);
        send_frame(32'h5A, 32'hC3, 8, 1'b1);
        pop_head(v, l, r);
        n_checks++;
        if ({v, l, r} !== {1'b1, 32'hABCD_1234}) begin
            n_fail++;
            $display("FAIL slot24: got v=%b %h/%h, want 1 abcd/1234", v, l, r);
        end
        pop_head(v, l, r);
        n_checks++;
        if ({v, l, r} !== {1'b1, 32'h5A00_C300}) begin
            n_fail++;
            $display("FAIL slot8: got v=%b %h/%h, want 1 5a00/c300", v, l, r);
        end
    endtask

    task automatic test_disable_and_reset();
        logic v;
        logic [15:0] l, r;
        restart();
        send_frame(32'h0101, 32'h0202, 16, 1'b1);
        send_frame(32'h0303, 32'h0404, 16, 1'b1);
        repeat (5) send_edge(1'b0, 1'b1);
        n_checks++;
        if (sample_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_disable_valid: got %b, want 1", sample_valid_o);
        end
        en_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sample_valid_o, sample_left_o} !== 17'd0) begin
            n_fail++;
            $display("FAIL disable_flush: got v=%b l=%h, want 0", sample_valid_o, sample_left_o);
        end
        restart();
        for (int i = 0; i < 5; i++) send_frame(32'h0700 + i, 32'h0800 + i, 16, 1'b1);
        en_i = 1'b0;
        @(negedge clk);
        en_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_survives_en: got %b, want 1", overrun_o);
        end
        send_sync();
        send_frame(32'h0909, 32'h0A0A, 16, 1'b1);
        send_frame(32'h0B0B, 32'h0C0C, 16, 1'b1);
        repeat (4) send_edge(1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sample_valid_o, overrun_o, sample_left_o} !== 18'd0 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL mid_frame_reset: got v=%b ovr=%b l=%h st=%0d, want 0 0 0 IDLE",
                     sample_valid_o, overrun_o, sample_left_o, dut.state);
        end
        rst = 1'b0;
        @(negedge clk);
        send_sync();
        send_frame(32'hC0DE, 32'hF00D, 16, 1'b1);
        pop_head(v, l, r);
        n_checks++;
        if ({v, l, r} !== {1'b1, 32'hC0DE_F00D} || sample_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_pair: got v=%b %h/%h then v=%b, want 1 c0de/f00d then 0",
                     v, l, r, sample_valid_o);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_mid_right_enable();
        test_overrun();
        test_slot_width();
        test_disable_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
